// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - AHB-Lite bus codes and error-FSM encoding for the BRAM bridge
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_OKAY = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } err_state_t;

endpackage

// File: rtl/ahb_bram_bytemask.sv
// rtl/ahb_bram_bytemask.sv - HSIZE/HADDR[1:0] to byte-lane mask and alignment check
module ahb_bram_bytemask
    import ahb_pkg::*;
(
    input  logic [2:0] size,
    input  logic [1:0] addr_lo,
    output logic [3:0] mask,
    output logic       illegal
);

    always_comb begin
        mask    = 4'b0000;
        illegal = 1'b0;
        case (size)
            HSIZE_BYTE: mask = 4'b0001 << addr_lo;
            HSIZE_HALF: begin
                mask    = addr_lo[1] ? 4'b1100 : 4'b0011;
                illegal = addr_lo[0];
            end
            HSIZE_WORD: begin
                mask    = 4'b1111;
                illegal = (addr_lo != 2'b00);
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ahb_bram_bridge.sv
// rtl/ahb_bram_bridge.sv - zero-wait AHB-Lite slave in front of a byte-enabled block RAM
module ahb_bram_bridge
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic [3:0]            HPROT,
    input  logic                  HWRITE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [31:0]           HRDATA,
    output logic [ADDR_WIDTH-1:0] BRAM_RDADDR,
    output logic [ADDR_WIDTH-1:0] BRAM_WRADDR,
    output logic [31:0]           BRAM_WDATA,
    output logic [3:0]            BRAM_WRITE,
    input  logic [31:0]           BRAM_RDATA
);

    logic [3:0]            dec_mask;
    logic                  dec_illegal;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  sample;
    logic                  legal_wr;
    logic                  legal_rd;
    logic                  raw_hit;
    logic [3:0]            wr_mask;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [3:0]            fwd_mask;
    logic [31:0]           fwd_data;
    err_state_t            state;
    logic                  unused_bits;

    ahb_bram_bytemask u_bytemask (
        .size    (HSIZE),
        .addr_lo (HADDR[1:0]),
        .mask    (dec_mask),
        .illegal (dec_illegal)
    );

    assign word_idx    = HADDR[ADDR_WIDTH+1:2];
    assign sample      = HSEL & HREADY & HTRANS[1];
    assign legal_wr    = sample & ~dec_illegal & HWRITE;
    assign legal_rd    = sample & ~dec_illegal & ~HWRITE;
    // The RAM reads old contents on the edge it writes, so a same-word read must be patched.
    assign raw_hit     = legal_rd & (wr_mask != 4'b0000) & (wr_addr == word_idx);
    assign unused_bits = ^{HPROT, HADDR[31:ADDR_WIDTH+2]};

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_mask  <= 4'b0000;
            wr_addr  <= '0;
            fwd_mask <= 4'b0000;
            fwd_data <= 32'h0;
        end else if (HREADY) begin
            wr_mask  <= legal_wr ? dec_mask : 4'b0000;
            fwd_mask <= raw_hit ? wr_mask : 4'b0000;
            if (legal_wr) wr_addr <= word_idx;
            if (raw_hit) fwd_data <= HWDATA;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= ST_OKAY;
            HREADYOUT <= 1'b1;
            HRESP     <= HRESP_OKAY;
        end else begin
            case (state)
                ST_ERR1: begin
                    state     <= ST_ERR2;
                    HREADYOUT <= 1'b1;
                    HRESP     <= HRESP_ERROR;
                end
                default: begin
                    if (sample && dec_illegal) begin
                        state     <= ST_ERR1;
                        HREADYOUT <= 1'b0;
                        HRESP     <= HRESP_ERROR;
                    end else begin
                        state     <= ST_OKAY;
                        HREADYOUT <= 1'b1;
                        HRESP     <= HRESP_OKAY;
                    end
                end
            endcase
        end
    end

    always_comb begin
        HRDATA = BRAM_RDATA;
        for (int b = 0; b < 4; b++) begin
            if (fwd_mask[b]) HRDATA[b*8 +: 8] = fwd_data[b*8 +: 8];
        end
    end

    assign BRAM_RDADDR = word_idx;
    assign BRAM_WRADDR = wr_addr;
    assign BRAM_WDATA  = HWDATA;
    assign BRAM_WRITE  = wr_mask;

endmodule
